// File: rtl/cycle_uart_out.sv
// UART transmit path: word FIFO feeding an 8N1 serializer that sends each
// word as BYTES frames, least-significant byte first.
module cycle_uart_out #(
    parameter int WORD_SIZE = 32,
    parameter int WORD_PART = 8,
    parameter int MEM_SIZE  = 64,
    parameter int CLQ_FREQ  = 200_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic                 clock,
    input  logic                 rstn,
    input  logic                 write_req,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic                 tx,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 word_done
);
    localparam int BIT_TICKS = CLQ_FREQ / BAUD_RATE;
    localparam int BYTES     = WORD_SIZE / WORD_PART;
    localparam int AW        = $clog2(MEM_SIZE);
    localparam int TW        = $clog2(BIT_TICKS + 1);
    localparam int BW        = $clog2(WORD_PART + 1);
    localparam int YW        = $clog2(BYTES + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] mem [MEM_SIZE];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count, count_nxt;
    logic [WORD_SIZE-1:0] shreg;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bit_idx;
    logic [YW-1:0]        byte_idx;
    logic                 push, pop, tick_end;

    assign push     = write_req && !full;
    assign pop      = (state == IDLE) && !empty;
    assign tick_end = (tick == TW'(BIT_TICKS - 1));

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    // Pointers wrap naturally since MEM_SIZE is a power of two.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(MEM_SIZE));
            empty <= (count_nxt == '0);
        end
    end

    // tx is registered: the value for the next bit is loaded on the edge that
    // ends the current bit, so every bit lasts exactly BIT_TICKS clocks.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            word_done <= 1'b0;
            shreg     <= '0;
            tick      <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
        end else begin
            word_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (!empty) begin
                        shreg    <= mem[rd_ptr];
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        tick     <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick_end) begin
                        tick    <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_end) begin
                        tick  <= '0;
                        shreg <= shreg >> 1;
                        if (bit_idx == BW'(WORD_PART - 1)) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_end) begin
                        tick <= '0;
                        if (byte_idx != YW'(BYTES - 1)) begin
                            byte_idx <= byte_idx + 1'b1;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            tx        <= 1'b1;
                            busy      <= 1'b0;
                            word_done <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cycle_uart_out.sv
// Scoreboard bench: writes push expected words, a line monitor decodes the
// tx frames and pops/compares, a second monitor checks word_done timing.
module tb_cycle_uart_out;
    localparam int BT    = 10;
    localparam int FRAME = 10 * BT;
    localparam int WORDT = 4 * FRAME;

    logic        clock = 1'b0;
    logic        rstn = 1'b1;
    logic        write_req = 1'b0;
    logic [31:0] data_in = '0;
    logic        tx, full, empty, busy, word_done;

    cycle_uart_out #(
        .WORD_SIZE(32), .WORD_PART(8), .MEM_SIZE(4),
        .CLQ_FREQ(1_000_000), .BAUD_RATE(100_000)
    ) dut (
        .clock(clock), .rstn(rstn), .write_req(write_req), .data_in(data_in),
        .tx(tx), .full(full), .empty(empty), .busy(busy), .word_done(word_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int          compared = 0, mismatched = 0;
    logic [31:0] exp_q[$];
    int          done_q[$];
    int          dn_cnt = 0;
    int          wcyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_evt(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got no event within bound, required event", name);
    endtask

    // Samples one frame at mid-bit; offset 0 is the first low cycle.
    task automatic rx_frame(output bit ok, output logic [7:0] b, output bit fr_ok);
        int k;
        ok = 1; fr_ok = 1; b = '0;
        for (int c = 1; c <= 95; c++) begin
            @(negedge clock);
            if (!rstn) begin ok = 0; return; end
            if (c % 10 == 5) begin
                k = c / 10;
                if (k == 0)      fr_ok &= (tx == 1'b0);
                else if (k == 9) fr_ok &= (tx == 1'b1);
                else             b[k-1] = tx;
            end
        end
    endtask

    initial begin : line_monitor
        logic prev, ok, fok, fr_all, tim_ok;
        logic [7:0]  b;
        logic [31:0] w, ew;
        int nb, wstart;
        prev = 1'b1; nb = 0; wstart = 0; fr_all = 1; tim_ok = 1; w = '0;
        forever begin
            @(negedge clock);
            if (!rstn) begin
                nb = 0; prev = 1'b1;
            end else if (prev && !tx) begin
                if (nb == 0) begin
                    wstart = cyc; tim_ok = 1; fr_all = 1; w = '0;
                end else begin
                    tim_ok &= (cyc == wstart + FRAME * nb);
                end
                rx_frame(ok, b, fok);
                if (!ok) begin
                    nb = 0; prev = 1'b1;
                end else begin
                    w[8*nb +: 8] = b;
                    fr_all &= fok;
                    nb++;
                    if (nb == 4) begin
                        nb = 0;
                        done_q.push_back(wstart + WORDT);
                        if (exp_q.size() == 0) begin
                            compared++; mismatched++;
                            $display("FAIL unexpected_word: got 0x%08h required none", w);
                        end else begin
                            ew = exp_q.pop_front();
                            check("word", w, ew);
                            check("frame_bits", fr_all, 1'b1);
                            check("byte_timing", tim_ok, 1'b1);
                        end
                    end
                    prev = tx;
                end
            end else begin
                prev = tx;
            end
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge clock);
            if (rstn && word_done) begin
                dn_cnt++;
                if (done_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL word_done_spurious: got pulse at %0d required none", cyc);
                end else begin
                    check("word_done_cycle", cyc, done_q.pop_front());
                end
            end
        end
    end

    task automatic write_word(input logic [31:0] w, input bit accept);
        @(negedge clock);
        write_req = 1'b1; data_in = w; wcyc = cyc;
        if (accept) exp_q.push_back(w);
    endtask

    task automatic write_end();
        @(negedge clock);
        write_req = 1'b0;
    endtask

    task automatic wait_tx_fall(output int t, input string name);
        int g = 0;
        while (tx !== 1'b0 && g < 2000) begin @(negedge clock); g++; end
        if (g >= 2000) fail_evt(name);
        t = cyc;
    endtask

    task automatic drain(input int budget, input string name);
        int g = 0;
        while ((exp_q.size() != 0 || busy || !empty) && g < budget) begin
            @(negedge clock); g++;
        end
        if (g >= budget) fail_evt(name);
        repeat (3) @(negedge clock);
    endtask

    initial begin : stim
        int tf, lows, d0, g;
        logic [31:0] r;
        // reset state
        #1 rstn = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_tx", tx, 1'b1);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_word_done", word_done, 1'b0);
        rstn = 1'b1;
        lows = 0;
        repeat (1000) begin @(negedge clock); if (tx !== 1'b1) lows++; end
        check("idle_low_cycles", lows, 0);

        // single word
        d0 = dn_cnt;
        write_word(32'hA5C30F81, 1);
        tf = wcyc;
        write_end();
        wait_tx_fall(tf, "single_tx_fall");
        check("start_latency", tf - wcyc, 2);
        drain(600, "single_drain");
        check("single_done_count", dn_cnt - d0, 1);

        // back-to-back words, one idle cycle between them
        write_word(32'h00000001, 1);
        write_word(32'hFFFFFFFF, 1);
        write_end();
        g = 0;
        while (word_done !== 1'b1 && g < 1000) begin @(negedge clock); g++; end
        if (g >= 1000) fail_evt("b2b_word_done");
        check("b2b_idle_tx", tx, 1'b1);
        check("b2b_empty_before_pop", empty, 1'b0);
        @(negedge clock);
        check("b2b_next_start", tx, 1'b0);
        check("b2b_empty_after_pop", empty, 1'b1);
        drain(1000, "b2b_drain");

        // overflow with a 4-deep FIFO: sixth write is dropped
        for (int i = 0; i < 6; i++) begin
            write_word(32'h5A000000 + i, i < 5);
            if (i == 4) check("ovf_full_before", full, 1'b0);
            if (i == 5) check("ovf_full_at_6th", full, 1'b1);
        end
        write_end();
        drain(5 * (WORDT + 1) + 100, "ovf_drain");

        // reset during DATA bit 3 of byte 1, with a second word queued
        write_word(32'hDEADBEEF, 1);
        write_word(32'hCAFEF00D, 1);
        write_end();
        wait_tx_fall(tf, "rst_mid_tx_fall");
        while (cyc < tf + FRAME + BT + 3 * BT + 5) @(negedge clock);
        check("mid_busy", busy, 1'b1);
        #2 rstn = 1'b0;
        exp_q.delete();
        done_q.delete();
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_empty", empty, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        repeat (3) @(negedge clock);
        rstn = 1'b1;
        repeat (5) @(negedge clock);
        check("post_rst_tx", tx, 1'b1);
        write_word(32'h12345678, 1);
        write_end();
        drain(600, "post_rst_drain");

        // stream of 64 random words with full-based flow control
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            g = 0;
            while (full && g < 2000) begin write_req = 1'b0; @(negedge clock); g++; end
            if (g >= 2000) fail_evt("loop_full_stuck");
            r = $urandom;
            write_req = 1'b1; data_in = r;
            exp_q.push_back(r);
        end
        write_end();
        drain(64 * (WORDT + 1) + 500, "loop_drain");
        check("loop_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/cycle_uart_out.md
Name: cycle_uart_out

Overview:
Transmit-side counterpart of the UART input path. It accepts 32-bit words from the core into an internal FIFO and breaks each word into WORD_PART-bit bytes. Each byte is serialised onto a single TX line as 8N1 UART frames. It sits between the core's write interface and the board TX pin, and must produce frames the input path reassembles into the identical word.

Parameters:
WORD_SIZE, 32, width of a core word; must be a multiple of WORD_PART
WORD_PART, 8, bits per UART frame (data bits)
MEM_SIZE, 64, FIFO depth in words; power of two
CLQ_FREQ, 200_000_000, clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s

Ports:
clock  in  1  system clock, all logic rising-edge
rstn  in  1  asynchronous active-low reset
write_req  in  1  push data_in into FIFO this cycle
data_in  in  WORD_SIZE  word to transmit
tx  out  1  serial line, idle high
full  out  1  FIFO holds MEM_SIZE words
empty  out  1  FIFO holds no words
busy  out  1  serializer not in IDLE
word_done  out  1  one-cycle pulse after last stop bit of a word

Behaviour:
- Reset (rstn low, asynchronous): tx=1, full=0, empty=1, busy=0, word_done=0. FIFO pointers and count are cleared, and the FSM goes to IDLE. A frame in flight is abandoned and tx returns high immediately.
- BIT_TICKS = CLQ_FREQ/BAUD_RATE (integer truncation). At the default parameters this is 1736. A bit period is exactly BIT_TICKS clocks.
- BYTES = WORD_SIZE/WORD_PART, which is 4 at the default parameters.
- FIFO write:
  - Accepted iff write_req && !full in that cycle.
  - A write while full is dropped silently and FIFO state is unchanged.
  - A pop in the same cycle as a full-state write does not make room; that write is still dropped.
- FIFO status: full and empty are registered from the count and update the cycle after the push or pop.
- FIFO pointers: wrap modulo MEM_SIZE.
- Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If !empty: pop the head word into a shift register, set byte_idx=0 and bit counters=0, then go to START on the next cycle.
- START:
  - tx=0 for BIT_TICKS clocks, then go to DATA with bit_idx=0.
- DATA:
  - tx = current byte bit[bit_idx], LSB first, each bit held for BIT_TICKS.
  - After bit WORD_PART-1, go to STOP.
- STOP:
  - tx=1 for BIT_TICKS clocks.
  - If byte_idx<BYTES-1, then byte_idx++ and go to START directly, with no extra idle cycle.
  - Otherwise, pulse word_done for 1 cycle and go to IDLE.
- Byte order: byte 0 = data_in[WORD_PART-1:0] is sent first, up to the MSB byte last.
- Latency:
  - write_req high at cycle N into an empty FIFO gives empty=0 at N+1 and the pop at N+1.
  - tx falls at N+2.
  - Per byte: (WORD_PART+2)*BIT_TICKS clocks.
  - Between words with a non-empty FIFO: exactly 1 IDLE cycle with tx=1 after word_done.
- busy: high in START, DATA and STOP.
- The word being transmitted has already left the FIFO, so full and empty reflect only queued words.
- Writes during transmission are accepted normally, up to MEM_SIZE queued words.

Test Plan:
- Reset: hold rstn=0 at CLQ_FREQ=1_000_000 and BAUD_RATE=100_000 (BIT_TICKS=10) -> tx=1, empty=1, full=0, busy=0.
  - Release rstn without writing -> tx stays 1 for 1000 cycles.
- Single word: write 0xA5C30F81 -> tx falls 2 cycles after write_req.
  - Bytes decode as 0x81, 0x0F, 0xC3, 0xA5, each frame being start=0, 8 bits LSB-first, stop=1, 100 clocks per frame.
  - word_done pulses once, 400 clocks after tx fell.
- Back-to-back: write 0x00000001 then 0xFFFFFFFF on consecutive cycles -> 8 frames.
  - Exactly one idle cycle (tx=1) between word_done and the next start bit.
  - empty=1 the cycle after the second pop.
- Full/overflow: with MEM_SIZE=4, write 6 words on consecutive cycles starting from an empty FIFO.
  - The first word is popped and 4 are queued, so full=1 by the 6th write and that write is dropped.
  - Exactly 5 words are transmitted, in order.
- Reset mid-frame: assert rstn=0 during DATA bit 3 of byte 1 -> tx=1 asynchronously and FIFO empty.
  - After release, a new word 0x12345678 transmits cleanly as 0x78, 0x56, 0x34, 0x12.
- Loopback: connect tx to cycle_uart_in (same CLQ_FREQ/BAUD_RATE) and send 64 random words -> the receiver FIFO holds the identical words in order.
